// File: rtl/masking_pkg.sv
// Shared definitions for the masked gadget unit: op encoding and share-pair indexing.
package masking_pkg;

    typedef enum logic [1:0] {
        OP_NOT     = 2'd0,
        OP_XOR     = 2'd1,
        OP_AND     = 2'd2,
        OP_REFRESH = 2'd3
    } op_e;

    function automatic int npairs(input int s);
        return s * (s - 1) / 2;
    endfunction

    // Symmetric: pair (i,j) and (j,i) map to the same randomness word.
    function automatic int pair_idx(input int i, input int j, input int s);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        return lo * s - lo * (lo + 1) / 2 + (hi - lo - 1);
    endfunction

endpackage

// File: rtl/dom_and_gadget.sv
// DOM-indep masked AND: cross terms and inner-domain products are registered on load,
// compression of the registered terms is combinational.
module dom_and_gadget
    import masking_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SHARES = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              load_i,
    input  logic [SHARES*WIDTH-1:0]           a_i,
    input  logic [SHARES*WIDTH-1:0]           b_i,
    input  logic [npairs(SHARES)*WIDTH-1:0]   r_i,
    output logic [SHARES*WIDTH-1:0]           z_o
);

    localparam int NPAIRS = npairs(SHARES);

    logic [SHARES-1:0][WIDTH-1:0]              a_w, b_w, z_w;
    logic [NPAIRS-1:0][WIDTH-1:0]              r_w;
    logic [SHARES-1:0][WIDTH-1:0]              inner_d, inner_q;
    logic [SHARES-1:0][SHARES-1:0][WIDTH-1:0]  cross_d, cross_q;

    assign a_w = a_i;
    assign b_w = b_i;
    assign r_w = r_i;

    // The register stage between cross-term generation and compression is what
    // keeps the glitchy recombination from seeing two domains unmasked.
    always_comb begin
        cross_d = cross_q;
        inner_d = inner_q;
        if (load_i) begin
            for (int i = 0; i < SHARES; i++) begin
                inner_d[i] = a_w[i] & b_w[i];
                for (int j = 0; j < SHARES; j++) begin
                    if (i != j) begin
                        cross_d[i][j] = (a_w[i] & b_w[j]) ^ r_w[pair_idx(i, j, SHARES)];
                    end else begin
                        cross_d[i][j] = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cross_q <= '0;
            inner_q <= '0;
        end else begin
            cross_q <= cross_d;
            inner_q <= inner_d;
        end
    end

    // Diagonal cross entries are held at zero, so folding them in is harmless.
    always_comb begin
        for (int i = 0; i < SHARES; i++) begin
            z_w[i] = inner_q[i];
            for (int j = 0; j < SHARES; j++) begin
                z_w[i] = z_w[i] ^ cross_q[i][j];
            end
        end
    end

    assign z_o = z_w;

endmodule

// File: rtl/masked_gadget_unit.sv
// Masked boolean gadget unit: NOT/XOR/REFRESH in one cycle, DOM AND in two,
// with a valid/ready handshake on both sides and back-to-back acceptance in DONE.
module masked_gadget_unit
    import masking_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SHARES = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [1:0]                        op_i,
    input  logic [SHARES*WIDTH-1:0]           a_shares_i,
    input  logic [SHARES*WIDTH-1:0]           b_shares_i,
    input  logic [npairs(SHARES)*WIDTH-1:0]   rand_i,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [SHARES*WIDTH-1:0]           z_shares_o
);

    localparam int NPAIRS = npairs(SHARES);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CROSS = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    if (SHARES < 2 || SHARES > 8) begin : g_bad_shares
        $error("masked_gadget_unit: SHARES must be in 2..8");
    end

    logic [1:0]                   state_d, state_q;
    logic [SHARES-1:0][WIDTH-1:0] a_w, b_w, z_d, z_q, and_z;
    logic [NPAIRS-1:0][WIDTH-1:0] r_w;
    logic [WIDTH-1:0]             rsum;
    logic                         accept;
    logic                         and_load;
    op_e                          op;

    assign a_w      = a_shares_i;
    assign b_w      = b_shares_i;
    assign r_w      = rand_i;
    assign op       = op_e'(op_i);
    assign in_ready = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
    assign accept   = in_valid & in_ready;
    assign and_load = accept & (op == OP_AND);

    dom_and_gadget #(
        .WIDTH  (WIDTH),
        .SHARES (SHARES)
    ) u_and (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (and_load),
        .a_i    (a_shares_i),
        .b_i    (b_shares_i),
        .r_i    (rand_i),
        .z_o    (and_z)
    );

    always_comb begin
        case (state_q)
            ST_CROSS: state_d = ST_DONE;
            ST_DONE:  state_d = out_ready ? ST_IDLE : ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
        if (accept) begin
            state_d = (op == OP_AND) ? ST_CROSS : ST_DONE;
        end
    end

    // Acceptance never coincides with CROSS, so the two z sources are exclusive.
    always_comb begin
        z_d  = z_q;
        rsum = '0;
        if (state_q == ST_CROSS) begin
            z_d = and_z;
        end
        if (accept && op != OP_AND) begin
            case (op)
                OP_NOT: begin
                    z_d    = a_w;
                    z_d[0] = ~a_w[0];
                end
                OP_XOR: begin
                    for (int k = 0; k < SHARES; k++) z_d[k] = a_w[k] ^ b_w[k];
                end
                default: begin
                    for (int k = 0; k < SHARES - 1; k++) begin
                        z_d[k] = a_w[k] ^ r_w[k];
                        rsum   = rsum ^ r_w[k];
                    end
                    z_d[SHARES-1] = a_w[SHARES-1] ^ rsum;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
        end
    end

    assign out_valid  = (state_q == ST_DONE);
    assign z_shares_o = z_q;

endmodule

// File: doc/masked_gadget_unit.md
MASKED_GADGET_UNIT -- requirements
Module: masked_gadget_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of one share.
REQ-002 SHALL have parameter SHARES, default 8: share count; legal range 2..8, any other value is an elaboration error.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: request present.
REQ-006 SHALL have port in_ready, output, 1: request accepted when in_valid & in_ready at a clock edge.
REQ-007 SHALL have port op_i, input, 2: 0=NOT, 1=XOR, 2=AND, 3=REFRESH.
REQ-008 SHALL have port a_shares_i, input, SHARES*WIDTH: operand A; share k at bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port b_shares_i, input, SHARES*WIDTH: operand B, same packing; ignored for NOT and REFRESH.
REQ-010 SHALL have port rand_i, input, NPAIRS*WIDTH where NPAIRS = SHARES*(SHARES-1)/2: fresh randomness, one WIDTH word per share pair.
REQ-011 SHALL have port out_valid, output, 1: result present.
REQ-012 SHALL have port out_ready, input, 1: result consumed when out_valid & out_ready at a clock edge.
REQ-013 SHALL have port z_shares_o, output, SHARES*WIDTH: result shares, same packing.

Function
REQ-014 SHALL sample op_i, a_shares_i, b_shares_i and rand_i only on acceptance; later changes to them have no effect on the operation in flight.
REQ-015 SHALL implement FSM IDLE, CROSS, DONE: IDLE -> CROSS on accepting AND; IDLE -> DONE on accepting any other op; CROSS -> DONE unconditionally; DONE -> IDLE on out_valid & out_ready with no new acceptance.
REQ-016 SHALL drive in_ready = (state==IDLE) | (state==DONE & out_ready); acceptance in DONE moves directly to CROSS or DONE per the new op (back-to-back).
REQ-017 SHALL drive out_valid = (state==DONE), registered, with no combinational path from in_valid.
REQ-018 SHALL give latency from acceptance edge to out_valid high: 1 cycle for NOT/XOR/REFRESH, 2 cycles for AND.
REQ-019 NOT SHALL produce z_0 = ~a_0 and z_k = a_k for k>0.
REQ-020 XOR SHALL produce z_k = a_k ^ b_k for every k.
REQ-021 REFRESH SHALL produce z_k = a_k ^ r_k for k<SHARES-1, and z_(S-1) = a_(S-1) ^ r_0 ^ ... ^ r_(S-2), using rand words 0..S-2.
REQ-022 AND SHALL be domain-oriented (DOM-indep).
REQ-023 For AND, cycle CROSS SHALL register c_ij = (a_i & b_j) ^ r_p(i,j) for every i≠j, with p symmetric in i,j.
REQ-024 For AND, the transition into DONE SHALL register z_i = (a_i & b_i) ^ XOR over j≠i of c_ij.
REQ-025 p(i,j) for i<j SHALL equal i*SHARES - i*(i+1)/2 + (j-i-1).
REQ-026 Unused rand_i words (for NOT/XOR, and words ≥S-1 for REFRESH) SHALL be ignored.
REQ-027 While out_valid & !out_ready, z_shares_o SHALL hold stable.
REQ-028 The XOR of all z shares SHALL equal the unmasked operation result for every op and every rand_i.

Reset
REQ-029 Assertion of rst_n low SHALL immediately force state IDLE, out_valid 0, z_shares_o all zero, and all cross-term registers zero.
REQ-030 After reset, in_ready SHALL be 1.
REQ-031 Reset asserted during CROSS or DONE SHALL discard the operation; no result is emitted after release.

Structure
REQ-032 Package masking_pkg SHALL hold the op enum (OP_NOT, OP_XOR, OP_AND, OP_REFRESH), function npairs(S), and function pair_idx(i,j,S).
REQ-033 The AND cross-term and compression logic SHALL be the sub-module dom_and_gadget, parametrised by WIDTH and SHARES.
REQ-034 FSM, handshake and NOT/XOR/REFRESH datapath SHALL reside in masked_gadget_unit.

Verification
REQ-035 NOT: SHARES=8, A=8'hAA split with random shares, out_ready=1 -> out_valid one cycle after acceptance, recombined z = 8'h55.
REQ-036 XOR/AND: A=8'hAA, B=8'h0F, random shares and rand_i -> XOR recombines to 8'hA5 after 1 cycle; AND recombines to 8'h0A after 2 cycles; repeat for SHARES=2 and 3.
REQ-037 REFRESH: A=8'h3C, rand_i nonzero -> recombined 8'h3C, and at least one share differs from the input share.
REQ-038 Backpressure: out_ready=0 for 3 cycles after out_valid -> z_shares_o stable, in_ready=0; raising out_ready with in_valid=1 -> next request accepted on the same edge.
REQ-039 Reset: rst_n low during CROSS of an AND -> out_valid=0 and z_shares_o=0 immediately; out_valid stays 0 after release until a new request is accepted.
